// File: rtl/weight_load_ctrl.sv
// Weight load sequencer: pops one tile per iteration from the weight FIFO, streams it
// row by row into the PE shadow registers, then commits it with a swap once the array is idle.
module weight_load_ctrl #(
    parameter  int WEIGHT_BW   = 8,
    parameter  int NUM_PE_ROWS = 8,
    parameter  int MATRIX_SIZE = 8,
    parameter  int TILE_CNT_BW = 8,
    localparam int ROW_BW      = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1,
    localparam int ROW_W       = WEIGHT_BW * MATRIX_SIZE,
    localparam int TILE_W      = ROW_W * NUM_PE_ROWS
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [TILE_CNT_BW-1:0] cmd_num_tiles,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    input  logic [TILE_W-1:0]      fifo_data_out,
    input  logic                   pe_idle,
    output logic                   wload_valid,
    output logic [ROW_BW-1:0]      wload_row_idx,
    output logic [ROW_W-1:0]       wload_row_data,
    output logic                   wload_swap,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT,
        SWAP_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TILE_CNT_BW-1:0] r_tile_cnt;
    logic [TILE_CNT_BW-1:0] r_num_tiles;
    logic [ROW_BW-1:0]      r_row_cnt;
    logic [TILE_W-1:0]      r_buf;
    logic [ROW_W-1:0]       r_row_data;
    logic                   r_done;
    logic                   w_last_row;
    logic                   w_last_tile;
    logic                   w_swap;
    logic                   w_pop;
    logic                   w_valid;
    logic [ROW_BW-1:0]      w_next_row;

    assign w_last_row  = (r_row_cnt == ROW_BW'(NUM_PE_ROWS - 1));
    assign w_last_tile = (r_tile_cnt == (r_num_tiles - TILE_CNT_BW'(1)));
    assign w_next_row  = r_row_cnt + ROW_BW'(1);

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_valid      = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && (cmd_num_tiles != '0))
                    w_next_state = FETCH;
            end
            FETCH: begin
                if (!fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: w_next_state = SHIFT;
            SHIFT: begin
                w_valid = 1'b1;
                if (w_last_row)
                    w_next_state = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (pe_idle) begin
                    w_swap       = 1'b1;
                    w_next_state = w_last_tile ? IDLE : FETCH;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Row data register is loaded one cycle ahead so it lines up with the decoded wload_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_tile_cnt  <= '0;
            r_num_tiles <= '0;
            r_row_cnt   <= '0;
            r_buf       <= '0;
            r_row_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_num_tiles <= cmd_num_tiles;
                        r_tile_cnt  <= '0;
                        if (cmd_num_tiles == '0)
                            r_done <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_buf      <= fifo_data_out;
                    r_row_cnt  <= '0;
                    r_row_data <= fifo_data_out[ROW_W-1:0];
                end
                SHIFT: begin
                    if (!w_last_row) begin
                        r_row_cnt  <= w_next_row;
                        r_row_data <= r_buf[w_next_row * ROW_W +: ROW_W];
                    end
                end
                SWAP_WAIT: begin
                    if (pe_idle) begin
                        r_tile_cnt <= r_tile_cnt + TILE_CNT_BW'(1);
                        if (w_last_tile)
                            r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready        = (r_state == IDLE);
    assign busy             = (r_state != IDLE);
    assign fifo_read_enable = w_pop;
    assign wload_valid      = w_valid;
    assign wload_swap       = w_swap;
    assign wload_row_idx    = r_row_cnt;
    assign wload_row_data   = r_row_data;
    assign done             = r_done;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl: FIFO model with tagged tiles, negedge event monitor,
// and hand-computed latencies for each scenario.
module tb_weight_load_ctrl;

    localparam int WB     = 8;
    localparam int NR     = 8;
    localparam int MS     = 8;
    localparam int TB_W   = 8;
    localparam int RB     = 3;
    localparam int ROW_W  = WB * MS;
    localparam int TILE_W = ROW_W * NR;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [TB_W-1:0]   cmd_num_tiles;
    logic              fifo_empty;
    logic              fifo_read_enable;
    logic [TILE_W-1:0] fifo_data_out;
    logic              pe_idle;
    logic              wload_valid;
    logic [RB-1:0]     wload_row_idx;
    logic [ROW_W-1:0]  wload_row_data;
    logic              wload_swap;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    weight_load_ctrl #(
        .WEIGHT_BW  (WB),
        .NUM_PE_ROWS(NR),
        .MATRIX_SIZE(MS),
        .TILE_CNT_BW(TB_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_num_tiles   (cmd_num_tiles),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .fifo_data_out   (fifo_data_out),
        .pe_idle         (pe_idle),
        .wload_valid     (wload_valid),
        .wload_row_idx   (wload_row_idx),
        .wload_row_data  (wload_row_data),
        .wload_swap      (wload_swap),
        .busy            (busy),
        .done            (done)
    );

    // Tile with tag s: every byte of row r equals 16*s + r.
    function automatic logic [TILE_W-1:0] make_tile(input int s);
        logic [TILE_W-1:0] t;
        t = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < MS; c++)
                t[(r * MS + c) * WB +: WB] = WB'(16 * s + r);
        return t;
    endfunction

    function automatic logic [ROW_W-1:0] row_val(input int s, input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < MS; c++)
            v[c * WB +: WB] = WB'(16 * s + r);
        return v;
    endfunction

    // FIFO model: registered read data, valid the cycle after the pop
    int   seq_mem [32];
    int   wr_ptr    = 0;
    int   rd_ptr    = 0;
    int   cur_seq   = 0;
    int   underflow = 0;
    logic force_empty;
    logic [TILE_W-1:0] dout = '0;

    assign fifo_empty    = force_empty || (wr_ptr == rd_ptr);
    assign fifo_data_out = dout;

    always @(posedge clk) begin
        if (fifo_read_enable) begin
            if (wr_ptr == rd_ptr) begin
                underflow <= underflow + 1;
            end else begin
                dout    <= make_tile(seq_mem[rd_ptr]);
                cur_seq <= seq_mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1;
            end
        end
    end

    // Event monitor
    int cyc = 0;
    int pops = 0, rows = 0, row_err = 0, swaps = 0, done_cnt = 0, busy_cnt = 0;
    int last_acc = 0, last_pop = 0, last_row0 = 0, last_swap = 0, prev_swap = 0, last_done = 0;
    int exp_row = 0;
    logic ready_at_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_row <= 0;
        end else begin
            if (cmd_valid && cmd_ready) last_acc <= cyc;
            if (fifo_read_enable) begin
                pops     <= pops + 1;
                last_pop <= cyc;
            end
            if (wload_valid) begin
                rows <= rows + 1;
                if (wload_row_idx != RB'(exp_row) || wload_row_data != row_val(cur_seq, exp_row))
                    row_err <= row_err + 1;
                if (wload_row_idx == '0) last_row0 <= cyc;
                exp_row <= (exp_row + 1) % NR;
            end
            if (wload_swap) begin
                swaps     <= swaps + 1;
                prev_swap <= last_swap;
                last_swap <= cyc;
            end
            if (done) begin
                done_cnt      <= done_cnt + 1;
                last_done     <= cyc;
                ready_at_done <= cmd_ready;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s);
        seq_mem[wr_ptr] = s;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic send_cmd(input int n);
        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_num_tiles = TB_W'(n);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int p0, r0, e0, d0, s0, b0;

    task automatic snap();
        p0 = pops; r0 = rows; e0 = row_err; d0 = done_cnt; s0 = swaps; b0 = busy_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic hit;
        rstn          = 1'b0;
        cmd_valid     = 1'b0;
        cmd_num_tiles = '0;
        pe_idle       = 1'b1;
        force_empty   = 1'b0;

        // Reset state
        settle(3);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", wload_valid, 0);
        chk("rst_pop", fifo_read_enable, 0);
        chk("rst_swap", wload_swap, 0);
        chk("rst_row_idx", wload_row_idx, 0);
        chk("rst_row_data", wload_row_data, 0);
        @(negedge clk);
        #2 rstn = 1'b1;

        // One tile, FIFO ready, array idle
        push(0);
        snap();
        send_cmd(1);
        wait_done(d0 + 1, 40);
        settle(3);
        chk("t1_pops", pops - p0, 1);
        chk("t1_rows", rows - r0, 8);
        chk("t1_row_err", row_err - e0, 0);
        chk("t1_pop_lat", last_pop - last_acc, 1);
        chk("t1_row0_lat", last_row0 - last_pop, 2);
        chk("t1_swap_lat", last_swap - last_pop, 10);
        chk("t1_done_lat", last_done - last_swap, 1);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_ready_at_done", ready_at_done, 1);

        // Two tiles back to back
        push(1);
        push(2);
        snap();
        send_cmd(2);
        wait_done(d0 + 1, 60);
        settle(3);
        chk("t2_pops", pops - p0, 2);
        chk("t2_rows", rows - r0, 16);
        chk("t2_row_err", row_err - e0, 0);
        chk("t2_swaps", swaps - s0, 2);
        chk("t2_swap_gap", last_swap - prev_swap, 11);
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_done_lat", last_done - last_swap, 1);

        // FIFO empty for the first 5 FETCH cycles
        force_empty = 1'b1;
        push(3);
        snap();
        send_cmd(1);
        repeat (5) @(posedge clk);
        #1 force_empty = 1'b0;
        wait_done(d0 + 1, 40);
        settle(3);
        chk("t3_pops", pops - p0, 1);
        chk("t3_pop_lat", last_pop - last_acc, 6);
        chk("t3_row0_lat", last_row0 - last_pop, 2);
        chk("t3_swap_lat", last_swap - last_acc, 16);
        chk("t3_rows", rows - r0, 8);
        chk("t3_row_err", row_err - e0, 0);

        // Array busy for 20 cycles of SWAP_WAIT
        pe_idle = 1'b0;
        push(4);
        snap();
        send_cmd(1);
        repeat (30) @(posedge clk);
        #1 pe_idle = 1'b1;
        wait_done(d0 + 1, 40);
        settle(3);
        chk("t4_pops", pops - p0, 1);
        chk("t4_swaps", swaps - s0, 1);
        chk("t4_swap_lat", last_swap - last_acc, 31);
        chk("t4_row_err", row_err - e0, 0);

        // Zero-tile command
        snap();
        send_cmd(0);
        settle(3);
        chk("t5_done_lat", last_done - last_acc, 1);
        chk("t5_done_cnt", done_cnt - d0, 1);
        chk("t5_pops", pops - p0, 0);
        chk("t5_rows", rows - r0, 0);
        chk("t5_busy", busy_cnt - b0, 0);
        chk("t5_ready_at_done", ready_at_done, 1);

        // Command pulse while busy is ignored
        push(5);
        snap();
        send_cmd(1);
        send_cmd(3);
        wait_done(d0 + 1, 40);
        settle(30);
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_pops", pops - p0, 1);
        chk("t6_swaps", swaps - s0, 1);
        chk("t6_pop_lat", last_pop - last_acc, 1);

        // Reset during SHIFT row 3, then a clean command
        push(6);
        push(7);
        snap();
        send_cmd(1);
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #2;
            if (wload_valid && wload_row_idx == RB'(3)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t7_row3_seen", hit, 1);
        rstn = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_valid", wload_valid, 0);
        chk("t7_ready", cmd_ready, 1);
        chk("t7_pop", fifo_read_enable, 0);
        chk("t7_row_data", wload_row_data, 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        chk("t7_pops_before", pops - p0, 1);
        snap();
        send_cmd(1);
        wait_done(d0 + 1, 40);
        settle(3);
        chk("t7_pops_after", pops - p0, 1);
        chk("t7_rows", rows - r0, 8);
        chk("t7_row_err", row_err - e0, 0);
        chk("t7_swaps", swaps - s0, 1);
        chk("t7_swap_lat", last_swap - last_pop, 10);
        chk("t7_tile_tag", cur_seq, 7);
        chk("fifo_underflow", underflow, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
Sequencer between the weight FIFO and the systolic PE array.
- On a command, pops one weight tile per iteration from the FIFO and captures it locally.
- Streams the tile into the PE shadow weight registers one row per cycle.
- Pulses a swap once the array reports idle, committing the shadow weights to active.
- Repeats for the commanded number of tiles, then signals done.

Parameters:
- WEIGHT_BW, 8, bits per weight.
- NUM_PE_ROWS, 8, PE rows; rows streamed per tile.
- MATRIX_SIZE, 8, weights per row (PE columns).
- TILE_CNT_BW, 8, width of tile-count command.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  load command request.
- cmd_ready  out  1  controller can accept a command (state IDLE).
- cmd_num_tiles  in  TILE_CNT_BW  tiles to load; sampled on handshake.
- fifo_empty  in  1  weight FIFO empty flag.
- fifo_read_enable  out  1  FIFO pop strobe.
- fifo_data_out  in  WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE  FIFO registered read data; valid the cycle after the pop.
- pe_idle  in  1  array finished with its active weights.
- wload_valid  out  1  row data valid to PE shadow registers.
- wload_row_idx  out  $clog2(NUM_PE_ROWS)  destination row.
- wload_row_data  out  WEIGHT_BW*MATRIX_SIZE  row weights.
- wload_swap  out  1  one-cycle commit of shadow weights to active.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; tile_cnt, row_cnt and num_tiles are 0; tile buffer cleared.
  - Registered outputs are 0: done, wload_row_idx, wload_row_data.
  - Decoded outputs are cmd_ready=1, busy=0, and all strobes 0.
  - Reset mid-operation abandons the tile; no further FIFO pops or swaps occur.
- States: IDLE, FETCH, CAPTURE, SHIFT, SWAP_WAIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_num_tiles and clear tile_cnt.
  - If cmd_num_tiles==0: stay IDLE, done=1 next cycle, no FIFO access.
  - Otherwise go to FETCH.
  - cmd_valid is ignored outside IDLE.
- FETCH:
  - fifo_read_enable = !fifo_empty (combinational).
  - If !fifo_empty, go to CAPTURE; otherwise wait indefinitely.
  - Exactly one pop per tile.
- CAPTURE:
  - Latch fifo_data_out into the tile buffer, clear row_cnt, go to SHIFT.
- SHIFT:
  - wload_valid=1, wload_row_idx=row_cnt.
  - wload_row_data = buffer bits [WEIGHT_BW*MATRIX_SIZE*(r+1)-1 : WEIGHT_BW*MATRIX_SIZE*r], r=row_cnt.
  - Lasts NUM_PE_ROWS consecutive cycles, rows 0..NUM_PE_ROWS-1 ascending.
  - After the last row, go to SWAP_WAIT.
- SWAP_WAIT:
  - Hold until pe_idle=1. In that cycle wload_swap=1 (combinational from state & pe_idle) and tile_cnt increments.
  - If tile_cnt was num_tiles-1: go to IDLE, done=1 in the following cycle (coincident with cmd_ready=1).
  - Otherwise go to FETCH.
- Outputs during SHIFT only: wload_valid, wload_row_idx and wload_row_data are held/0 outside SHIFT (wload_valid=0).
- Minimum per-tile latency: NUM_PE_ROWS+3 cycles (FETCH, CAPTURE, NUM_PE_ROWS×SHIFT, SWAP_WAIT) with FIFO non-empty and pe_idle=1.
- Prefetch overlap: the next tile's FETCH/CAPTURE/SHIFT may run while the array computes; only the swap waits on pe_idle.
- pe_idle is ignored outside SWAP_WAIT; fifo_empty is ignored outside FETCH.
- Counters: tile_cnt is TILE_CNT_BW wide; num_tiles up to 2^TILE_CNT_BW-1 is supported with no wrap.

Test Plan:
- Reset, then 1-tile cmd, FIFO holds tile with row r bytes = r, pe_idle=1 -> 1 pop; 8 wload_valid cycles idx 0..7, row data bytes 0..7; swap 10 cycles after FETCH entry; done the next cycle.
- 2-tile cmd, FIFO pre-filled, pe_idle=1 -> 2 pops; 16 row writes; 2 swaps 11 cycles apart; single done pulse.
- FIFO empty for 5 cycles in FETCH -> no pop, wload_valid=0 throughout; pop occurs on the first non-empty cycle and timing shifts by exactly 5.
- pe_idle=0 for 20 cycles at SWAP_WAIT -> wload_swap stays 0 with no new pop; swap on the first pe_idle=1 cycle.
- cmd_num_tiles=0 -> no pop, no wload_valid, done=1 the cycle after acceptance; a cmd_valid pulse while busy is ignored (one done only).
- rstn asserted mid-SHIFT (row 3) -> immediately busy=0, wload_valid=0, cmd_ready=1; after release, a new 1-tile cmd completes normally.
